// File: rtl/argmax_stream.sv
`default_nettype none
// ============================================================================
// Module      : argmax_stream
// Description : Streaming top-2 argmax over DIM logits, LANES per beat; reports
//               winner, runner-up and their margin through a valid/ready output.
// Revision    : 1.0  initial release
// ============================================================================
module argmax_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int DIM        = 10,
    parameter int LANES      = 2,
    parameter int IDXW       = (DIM <= 1) ? 1 : $clog2(DIM),
    parameter int SIGNED_CMP = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [IDXW-1:0]             out_idx,
    output logic [DATA_WIDTH-1:0]       out_max,
    output logic [IDXW-1:0]             out_idx2,
    output logic [DATA_WIDTH-1:0]       out_max2,
    output logic [DATA_WIDTH:0]         out_margin
);

    localparam int             NBEATS    = (DIM + LANES - 1) / LANES;
    localparam int             BW        = (NBEATS <= 1) ? 1 : $clog2(NBEATS);
    localparam logic [BW-1:0]  LAST_BEAT = BW'(NBEATS - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [BW-1:0]           r_beat;
    logic [DATA_WIDTH-1:0]   r_best_val;
    logic [IDXW-1:0]         r_best_idx;
    logic                    r_best_vld;
    logic [DATA_WIDTH-1:0]   r_sec_val;
    logic [IDXW-1:0]         r_sec_idx;
    logic                    r_sec_vld;

    logic                    w_acc;
    logic                    w_last;
    logic [DATA_WIDTH-1:0]   w_lane [0:LANES-1];
    logic [IDXW-1:0]         w_lidx [0:LANES-1];
    logic                    w_lok  [0:LANES-1];

    logic [DATA_WIDTH-1:0]   w_bv  [0:LANES];
    logic [IDXW-1:0]         w_bi  [0:LANES];
    logic                    w_bok [0:LANES];
    logic [DATA_WIDTH-1:0]   w_sv  [0:LANES];
    logic [IDXW-1:0]         w_si  [0:LANES];
    logic                    w_sok [0:LANES];

    logic [DATA_WIDTH-1:0]   w_fin_sval;
    logic [IDXW-1:0]         w_fin_sidx;
    logic [DATA_WIDTH:0]     w_ext_b;
    logic [DATA_WIDTH:0]     w_ext_s;

    function automatic logic gt(input logic [DATA_WIDTH-1:0] a,
                                input logic [DATA_WIDTH-1:0] b);
        if (SIGNED_CMP != 0) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    // Only the final beat can carry lanes past DIM; earlier beats are always full.
    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            localparam int LAST_ELEM = (NBEATS - 1) * LANES + k;
            assign w_lane[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
            assign w_lidx[k] = IDXW'(r_beat) * IDXW'(LANES) + IDXW'(k);
            assign w_lok[k]  = (LAST_ELEM < DIM) || (r_beat != LAST_BEAT);
        end
    endgenerate

    always_comb begin
        w_bv[0]  = r_best_val;
        w_bi[0]  = r_best_idx;
        w_bok[0] = r_best_vld;
        w_sv[0]  = r_sec_val;
        w_si[0]  = r_sec_idx;
        w_sok[0] = r_sec_vld;
        for (int k = 0; k < LANES; k++) begin
            w_bv[k+1]  = w_bv[k];
            w_bi[k+1]  = w_bi[k];
            w_bok[k+1] = w_bok[k];
            w_sv[k+1]  = w_sv[k];
            w_si[k+1]  = w_si[k];
            w_sok[k+1] = w_sok[k];
            if (w_lok[k]) begin
                if (!w_bok[k] || gt(w_lane[k], w_bv[k])) begin
                    w_bv[k+1]  = w_lane[k];
                    w_bi[k+1]  = w_lidx[k];
                    w_bok[k+1] = 1'b1;
                    w_sv[k+1]  = w_bv[k];
                    w_si[k+1]  = w_bi[k];
                    w_sok[k+1] = w_bok[k];
                end else if (!w_sok[k] || gt(w_lane[k], w_sv[k])) begin
                    w_sv[k+1]  = w_lane[k];
                    w_si[k+1]  = w_lidx[k];
                    w_sok[k+1] = 1'b1;
                end
            end
        end
    end

    // With a single element there is no runner-up; mirror the winner so margin is 0.
    always_comb begin
        w_fin_sval = w_sok[LANES] ? w_sv[LANES] : w_bv[LANES];
        w_fin_sidx = w_sok[LANES] ? w_si[LANES] : w_bi[LANES];
        if (SIGNED_CMP != 0) begin
            w_ext_b = {w_bv[LANES][DATA_WIDTH-1], w_bv[LANES]};
            w_ext_s = {w_fin_sval[DATA_WIDTH-1], w_fin_sval};
        end else begin
            w_ext_b = {1'b0, w_bv[LANES]};
            w_ext_s = {1'b0, w_fin_sval};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && w_last) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            default: w_state_nxt = ST_ACCUM;
        endcase
    end

    assign w_acc  = in_valid && (r_state == ST_ACCUM);
    assign w_last = (r_beat == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_ACCUM;
            r_beat     <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
            r_best_vld <= 1'b0;
            r_sec_val  <= '0;
            r_sec_idx  <= '0;
            r_sec_vld  <= 1'b0;
            out_idx    <= '0;
            out_max    <= '0;
            out_idx2   <= '0;
            out_max2   <= '0;
            out_margin <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc) begin
                if (w_last) begin
                    r_beat     <= '0;
                    r_best_vld <= 1'b0;
                    r_sec_vld  <= 1'b0;
                    out_idx    <= w_bi[LANES];
                    out_max    <= w_bv[LANES];
                    out_idx2   <= w_fin_sidx;
                    out_max2   <= w_fin_sval;
                    out_margin <= w_ext_b - w_ext_s;
                end else begin
                    r_beat     <= r_beat + BW'(1);
                    r_best_val <= w_bv[LANES];
                    r_best_idx <= w_bi[LANES];
                    r_best_vld <= w_bok[LANES];
                    r_sec_val  <= w_sv[LANES];
                    r_sec_idx  <= w_si[LANES];
                    r_sec_vld  <= w_sok[LANES];
                end
            end else if (out_valid && out_ready) begin
                r_beat     <= '0;
                r_best_vld <= 1'b0;
                r_sec_vld  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_argmax_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_argmax_stream
// Description : Self-checking bench for argmax_stream; three instances
//               (DIM=6 signed, DIM=5 signed, DIM=6 unsigned), LANES=2.
// Revision    : 1.0  initial release
// ============================================================================
module tb_argmax_stream;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid   [3];
    logic        in_ready   [3];
    logic        out_valid  [3];
    logic        out_ready  [3];
    logic [31:0] in_data    [3];
    logic [2:0]  out_idx    [3];
    logic [2:0]  out_idx2   [3];
    logic [15:0] out_max    [3];
    logic [15:0] out_max2   [3];
    logic [16:0] out_margin [3];

    int dims [3] = '{6, 5, 6};
    bit sgn  [3] = '{1'b1, 1'b1, 1'b0};
    int fr   [6];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    argmax_stream #(.DATA_WIDTH(16), .DIM(6), .LANES(2), .SIGNED_CMP(1)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_idx(out_idx[0]), .out_max(out_max[0]), .out_idx2(out_idx2[0]),
        .out_max2(out_max2[0]), .out_margin(out_margin[0]));

    argmax_stream #(.DATA_WIDTH(16), .DIM(5), .LANES(2), .SIGNED_CMP(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_idx(out_idx[1]), .out_max(out_max[1]), .out_idx2(out_idx2[1]),
        .out_max2(out_max2[1]), .out_margin(out_margin[1]));

    argmax_stream #(.DATA_WIDTH(16), .DIM(6), .LANES(2), .SIGNED_CMP(0)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_idx(out_idx[2]), .out_max(out_max[2]), .out_idx2(out_idx2[2]),
        .out_max2(out_max2[2]), .out_margin(out_margin[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int key(input int x, input bit s);
        logic [15:0] t;
        t = x[15:0];
        return s ? int'($signed(t)) : int'(t);
    endfunction

    // Top-2 by value descending, earliest index first on ties.
    function automatic void model(input int v[6], input int dim, input bit s,
                                  output int bi, output int si, output int mg);
        bi = 0;
        for (int i = 1; i < dim; i++)
            if (key(v[i], s) > key(v[bi], s)) bi = i;
        si = -1;
        for (int i = 0; i < dim; i++)
            if (i != bi && (si < 0 || key(v[i], s) > key(v[si], s))) si = i;
        if (si < 0) si = bi;
        mg = key(v[bi], s) - key(v[si], s);
    endfunction

    task automatic check_res(input int u, input int bi, input int si, input int mg, input int v[6]);
        int bv, sv;
        bv = v[bi];
        sv = v[si];
        chk("out_idx",    {29'd0, out_idx[u]},    bi);
        chk("out_max",    {16'd0, out_max[u]},    {16'd0, bv[15:0]});
        chk("out_idx2",   {29'd0, out_idx2[u]},   si);
        chk("out_max2",   {16'd0, out_max2[u]},   {16'd0, sv[15:0]});
        chk("out_margin", {15'd0, out_margin[u]}, {15'd0, mg[16:0]});
    endtask

    task automatic send_frame(input int u, input int v[6], input int filler,
                              input bit gaps, input int hold);
        int dim, nb, bi, si, mg, hi;
        dim = dims[u];
        nb  = (dim + 1) / 2;
        model(v, dim, sgn[u], bi, si, mg);
        for (int b = 0; b < nb; b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    in_valid[u] = 1'b0;
                    in_data[u]  = $urandom;
                end
            end
            @(negedge clk);
            chk("out_valid_early", {31'd0, out_valid[u]}, 0);
            chk("in_ready_accum",  {31'd0, in_ready[u]},  1);
            hi = (2*b + 1 < dim) ? v[2*b + 1] : filler;
            in_valid[u] = 1'b1;
            in_data[u]  = {hi[15:0], v[2*b][15:0]};
            @(posedge clk);
            #1;
            in_valid[u] = 1'b0;
            in_data[u]  = $urandom;
        end
        chk("out_valid_latency", {31'd0, out_valid[u]}, 1);
        check_res(u, bi, si, mg, v);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid[u] = 1'($urandom_range(0, 1));
            in_data[u]  = $urandom;
            chk("in_ready_hold",  {31'd0, in_ready[u]},  0);
            chk("out_valid_hold", {31'd0, out_valid[u]}, 1);
            check_res(u, bi, si, mg, v);
        end
        @(negedge clk);
        in_valid[u]  = 1'b0;
        out_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[u] = 1'b0;
        chk("out_valid_cleared", {31'd0, out_valid[u]}, 0);
    endtask

    task automatic reset_check(input int u);
        chk("rst_out_valid", {31'd0, out_valid[u]},  0);
        chk("rst_in_ready",  {31'd0, in_ready[u]},   1);
        chk("rst_out_idx",   {29'd0, out_idx[u]},    0);
        chk("rst_out_max",   {16'd0, out_max[u]},    0);
        chk("rst_out_margin",{15'd0, out_margin[u]}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 3; u++) begin
            in_valid[u]  = 1'b0;
            out_ready[u] = 1'b0;
            in_data[u]   = '0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) reset_check(u);
        reset = 1'b0;

        // Directed frames
        fr = '{-3, -1, -7, -1, -2, -9};          send_frame(0, fr, 0, 1'b0, 0);
        fr = '{1, 2, 3, 9, 8, 0};                send_frame(0, fr, 0, 1'b0, 0);
        fr = '{0, 5, 2, 5, 1, 4};                send_frame(0, fr, 0, 1'b0, 0);
        fr = '{4, -6, 7, 7, 100, 0};             send_frame(1, fr, 32767, 1'b0, 0);
        fr = '{-32768, 32767, 0, 0, 0, 0};       send_frame(0, fr, 0, 1'b0, 0);
        fr = '{32767, -32768, -32768, -32768, -32768, -32768};
        send_frame(0, fr, 0, 1'b0, 0);
        fr = '{32'h7FFF, 32'h8000, 0, 0, 0, 0};  send_frame(2, fr, 0, 1'b0, 0);
        send_frame(0, fr, 0, 1'b0, 0);

        // Backpressure with gaps
        fr = '{10, -20, 30, 30, -5, 7};          send_frame(0, fr, 0, 1'b1, 5);
        send_frame(1, fr, 12345, 1'b1, 5);

        // Reset after two of three beats: the aborted frame must not surface
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            in_valid[0] = 1'b1;
            in_data[0]  = {16'd400 + 16'(b), 16'd300 + 16'(b)};
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            reset_check(0);
        end
        fr = '{1, 2, 3, 4, 6, 5};                send_frame(0, fr, 0, 1'b0, 0);

        // Randomized frames, mixing narrow (tie-prone) and full-range values
        for (int n = 0; n < 15; n++) begin
            for (int u = 0; u < 3; u++) begin
                bit narrow;
                narrow = 1'($urandom_range(0, 1));
                for (int i = 0; i < 6; i++)
                    fr[i] = narrow ? (int'($urandom_range(0, 3)) - 2) : int'($urandom & 32'hFFFF);
                send_frame(u, fr, int'($urandom), 1'b1, int'($urandom_range(0, 3)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/argmax_stream.md
Name: argmax_stream

Overview:
Streaming top-2 argmax for the classifier tail. It accepts DIM logits over a valid/ready input, LANES elements per beat. It reports the index and value of the maximum, the index and value of the runner-up, and their margin. It replaces the start/done argmax, which only produced the winning index and needed the whole vector presented in parallel.

Parameters:
DATA_WIDTH, 16, width of each logit element
DIM, 10, number of elements per frame (>=1)
LANES, 2, elements per input beat (1..DIM)
IDXW, (DIM<=1)?1:$clog2(DIM), width of index outputs
SIGNED_CMP, 1, 1 = two's-complement compare, 0 = unsigned compare

Ports:
clk  in  1  clock, single domain
reset  in  1  synchronous, active-high reset
in_valid  in  1  beat valid
in_ready  out  1  block can accept a beat
in_data  in  LANES*DATA_WIDTH  packed beat; lane k is bits [k*DATA_WIDTH +: DATA_WIDTH] and holds element beat*LANES+k
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_idx  out  IDXW  index of maximum
out_max  out  DATA_WIDTH  maximum value
out_idx2  out  IDXW  index of runner-up
out_max2  out  DATA_WIDTH  runner-up value
out_margin  out  DATA_WIDTH+1  out_max - out_max2, unsigned, always >= 0

Behaviour:
- Frame size: NBEATS = ceil(DIM/LANES) beats.
  - On the final beat, lanes whose element index is >= DIM are ignored entirely.
  - No in_last signal; an internal beat counter (0..NBEATS-1) delimits frames.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Reset: state=ACCUM, beat counter=0, out_valid=0, all result outputs=0, best/second-valid flags cleared. Any partial frame is discarded.
- ACCUM, on in_valid&&in_ready:
  - Lanes are folded in ascending element order through a combinational compare chain against the running (best, second) pair.
  - Update rule for an element e at index i:
    - If no best, or e > best: second <= best, best <= (e, i).
    - Else if no second, or e > second: second <= (e, i).
    - Strict compares: ties keep the earlier index, both for best and for second.
  - On the final beat, the folded result is registered into the output registers and the state moves to HOLD.
  - out_valid rises on the clock edge that accepts the final beat, so the result is visible the following cycle.
  - There is no other latency.
- in_valid low in ACCUM: all state holds; gaps between beats are legal.
- HOLD:
  - Outputs stay stable and in_ready=0 until out_ready=1.
  - On the out_valid&&out_ready edge: state=ACCUM, counter=0, running flags cleared, out_valid=0.
  - The next frame's first beat can be accepted the cycle after the handshake. No same-cycle pass-through.
- Compare mode: SIGNED_CMP selects a $signed or unsigned relational compare. The same mode applies to the margin computation.
- Margin:
  - Both operands are extended to DATA_WIDTH+1 bits (sign-extended if SIGNED_CMP, else zero-extended), then subtracted. This cannot overflow.
  - For DIM=1 there is no second element: out_idx2=out_idx, out_max2=out_max, out_margin=0.
- Reset asserted mid-frame or in HOLD: the next cycle is the reset state. No result is emitted for the aborted frame.
- in_data is sampled only on an accepted beat; X on unaccepted cycles must not propagate.

Test Plan:
- DIM=6, LANES=2, signed; beats {-3,-1},{-7,-1},{-2,-9} -> out_idx=1, out_max=-1, out_idx2=3, out_max2=-1, out_margin=0.
- DIM=6, LANES=2; frame {1,2,3,9,8,0} -> idx=3/max=9, idx2=4/max2=8, margin=1. Then frame {0,5,2,5,1,4} back-to-back -> idx=1, idx2=3, margin=0. out_valid asserts exactly 1 cycle after each final beat.
- Second instance DIM=5, LANES=2; frame {4,-6,7,7,100} with lane 1 of the last beat = 32767 (ignored) -> idx=4/max=100, idx2=2/max2=7, margin=93.
- Extremes, signed, DIM=6: {-32768,32767,0,0,0,0} -> idx=1, idx2=2, margin=32767. Add {32767,-32768,...} with -32768 as runner-up -> margin=65535 (17 bits).
- Unsigned mode, DIM=6: {0x7FFF,0x8000,...0} -> idx=1. Same data signed -> idx=0.
- Backpressure and reset:
  - out_ready low 5 cycles -> in_ready=0 and outputs stable throughout; random in_valid gaps give identical results.
  - reset pulsed after 2 of 3 beats -> no out_valid. A fresh full frame afterwards gives the correct result.
